reg_bus_sequencer: RTL
======================

Name: reg_bus_sequencer

Overview:
- Bus-side initiator for the core's one-hot register file: takes move commands (register-to-register or immediate-to-register) and drives the one-hot read/write enables and the shared data bus.
- Buffers commands in a small FIFO and runs each as a fixed READ→WRITE sequence, so the register file sees at most one read enable and one write enable active at a time.
- Sits between the core's instruction/control logic and the register file.

Parameters:
- REG_COUNT, 11, number of registers addressed; width of read_en/write_en.
- REG_WIDTH, 12, data bus width.
- IDX_W, 4, width of register index fields; must satisfy 2^IDX_W >= REG_COUNT.
- FIFO_DEPTH, 4, command buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command; equals !full.
- cmd_src  in  IDX_W  source register index; ignored when cmd_imm_sel=1.
- cmd_dst  in  IDX_W  destination register index.
- cmd_imm_sel  in  1  1 = write cmd_imm to the destination; 0 = copy from the source register.
- cmd_imm  in  REG_WIDTH  immediate value.
- bus_in  in  REG_WIDTH  register file dataout.
- bus_out  out  REG_WIDTH  register file datain.
- read_en  out  REG_COUNT  one-hot read select; all zero outside READ.
- write_en  out  REG_COUNT  one-hot write strobe; all zero outside WRITE.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- done  out  1  one-cycle pulse per completed move.
- err  out  1  one-cycle pulse per dropped illegal command.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO flushed; FSM goes to IDLE; hold register cleared to 0.
  - read_en=0, write_en=0, bus_out=0, busy=0, done=0, err=0, cmd_ready=1.
- Push: a command is accepted on any rising edge where cmd_valid && cmd_ready.
  - No bypass: a command entering an empty FIFO is popped at the earliest on the following cycle.
- FIFO full: cmd_ready=0; cmd_valid is ignored.
  - Push and pop in the same cycle when not full: both take effect and the count is unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, READ, WRITE.
- IDLE, FIFO non-empty: pop the head entry and latch src/dst/imm.
  - dst >= REG_COUNT, or src >= REG_COUNT with imm_sel=0: pulse err next cycle, drop the command, stay in IDLE.
  - imm_sel=1: hold<=cmd_imm, go to WRITE.
  - Otherwise: go to READ.
- READ, one cycle: read_en = onehot(src).
  - hold <= bus_in at the end of the cycle; the register file read is combinational.
  - Next state is WRITE.
- WRITE, one cycle: write_en = onehot(dst), bus_out = hold.
  - The register file samples on the closing edge.
  - Next state is IDLE; done=1 for exactly the following cycle.
- Output timing: read_en, write_en and bus_out are decoded only from registered state/index/hold, so they do not depend on cmd_* or bus_in within a cycle.
- bus_out keeps its last value outside WRITE.
- Latency, register move: popped in cycle N, READ in N+1, WRITE in N+2, done in N+3.
  - The done cycle is IDLE and may pop the next command, giving 3 cycles per move at full rate.
- Latency, immediate: popped in cycle N, WRITE in N+1, done in N+2.
- src == dst is legal; the register is rewritten with its own value.
- Reset during READ or WRITE: enables drop immediately with reset_n.
  - A write whose strobe is removed before the edge does not happen.
  - No done pulse for the aborted command.
- done and err never assert in the same cycle.

Optional Feature:
- Macro XFER_CNT_EN.
- Defined: adds output xfer_cnt (16 bits), reset to 0, incremented on each done pulse, wraps 0xFFFF→0, not incremented by err.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Immediate write: push {imm_sel=1, dst=8, imm=12'd900} → write_en=11'b001_0000_0000 and bus_out=900 two cycles after push; done one cycle later; read_en stays 0.
- Register move: bus_in model returns 12'd1600 when read_en=bit 9; push {src=9, dst=1} → READ cycle with read_en=11'b010_0000_0000, then WRITE with write_en=11'b000_0000_0010 and bus_out=1600, then done.
- Back-pressure: push 5 commands back to back with FIFO_DEPTH=4 and the FSM busy → cmd_ready=0 after the 4th accepted; the 5th is held until the first pop; all 5 complete in order with 5 done pulses.
- Illegal index: push {src=2, dst=12} → err pulse; no read_en or write_en activity; the next legal command executes normally.
- Reset mid-operation: assert reset_n=0 during WRITE → write_en=0 immediately; FIFO empty, busy=0, cmd_ready=1, no done.
- XFER_CNT_EN: preload xfer_cnt to 0xFFFF via 65535 moves (or force it), complete one more → xfer_cnt=0.

Source files
------------

// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer: bus-side initiator for the one-hot register file.
//
// Move commands (register-to-register or immediate-to-register) are buffered
// in a small FIFO and executed one at a time as a fixed READ -> WRITE sequence,
// so the register file never sees more than one read and one write enable.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready = FIFO not full
//   cmd_src, cmd_dst      source / destination register indices
//   cmd_imm_sel, cmd_imm  1 = write cmd_imm to dst instead of copying src
//   bus_in                register file dataout (combinational read)
//   bus_out               register file datain; holds its value outside WRITE
//   read_en, write_en     one-hot read select / write strobe
//   busy                  FSM not idle or FIFO non-empty
//   done, err             one-cycle pulses: move completed / illegal command dropped
//   xfer_cnt              (only with XFER_CNT_EN) 16-bit count of completed moves
//
// Optional feature: define XFER_CNT_EN to add the xfer_cnt output.

module reg_bus_sequencer #(
    parameter int unsigned REG_COUNT  = 11,
    parameter int unsigned REG_WIDTH  = 12,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [IDX_W-1:0]     cmd_src,
    input  logic [IDX_W-1:0]     cmd_dst,
    input  logic                 cmd_imm_sel,
    input  logic [REG_WIDTH-1:0] cmd_imm,
    input  logic [REG_WIDTH-1:0] bus_in,
    output logic [REG_WIDTH-1:0] bus_out,
    output logic [REG_COUNT-1:0] read_en,
    output logic [REG_COUNT-1:0] write_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err
`ifdef XFER_CNT_EN
    ,
    output logic [15:0]          xfer_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);
    // Index limit widened by one bit so REG_COUNT == 2^IDX_W still compares correctly.
    localparam logic [IDX_W:0] REG_LIMIT = (IDX_W + 1)'(REG_COUNT);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    function automatic logic [REG_COUNT-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = REG_COUNT'(1) << idx;
    endfunction

    // ---------------------------------------------------------------- FIFO
    logic [IDX_W-1:0]     src_mem [FIFO_DEPTH];
    logic [IDX_W-1:0]     dst_mem [FIFO_DEPTH];
    logic                 sel_mem [FIFO_DEPTH];
    logic [REG_WIDTH-1:0] imm_mem [FIFO_DEPTH];

    // Pointers carry an extra wrap bit to tell full from empty.
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic           full, empty, push, pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            src_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_src;
            dst_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_dst;
            sel_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_imm_sel;
            imm_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_imm;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    logic [IDX_W-1:0]     head_src, head_dst;
    logic                 head_sel, head_bad;
    logic [REG_WIDTH-1:0] head_imm;

    assign head_src = src_mem[rd_ptr_q[PTR_W-1:0]];
    assign head_dst = dst_mem[rd_ptr_q[PTR_W-1:0]];
    assign head_sel = sel_mem[rd_ptr_q[PTR_W-1:0]];
    assign head_imm = imm_mem[rd_ptr_q[PTR_W-1:0]];
    // The source index only matters for register-to-register moves.
    assign head_bad = ({1'b0, head_dst} >= REG_LIMIT) ||
                      (!head_sel && ({1'b0, head_src} >= REG_LIMIT));

    // ----------------------------------------------------------------- FSM
    state_e               state_q, state_d;
    logic [IDX_W-1:0]     src_q, src_d, dst_q, dst_d;
    logic [REG_WIDTH-1:0] hold_q, hold_d, last_out_q, last_out_d;
    logic                 done_q, done_d, err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            src_q      <= '0;
            dst_q      <= '0;
            hold_q     <= '0;
            last_out_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            hold_q     <= hold_d;
            last_out_q <= last_out_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Enables and bus_out decode only registered state, never cmd_* or bus_in.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        hold_d     = hold_q;
        last_out_d = last_out_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pop        = 1'b0;
        read_en    = '0;
        write_en   = '0;
        bus_out    = last_out_q;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_bad) begin
                        err_d = 1'b1;
                    end else begin
                        src_d = head_src;
                        dst_d = head_dst;
                        if (head_sel) begin
                            hold_d  = head_imm;
                            state_d = StWrite;
                        end else begin
                            state_d = StRead;
                        end
                    end
                end
            end
            StRead: begin
                read_en = onehot(src_q);
                hold_d  = bus_in;
                state_d = StWrite;
            end
            StWrite: begin
                write_en   = onehot(dst_q);
                bus_out    = hold_q;
                last_out_d = hold_q;
                done_d     = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle) || !empty;
    assign done = done_q;
    assign err  = err_q;

`ifdef XFER_CNT_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xfer_cnt_q <= '0;
        end else if (done_q) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
